alu_mul_seq: RTL

//  Sequencer that shares the single ALU between the pipeline EX stage and an iterative
//  32x32->32 (low word, MIPS mul) shift-add multiplier. Sits in front of the ALU port mux:

---
 rtl/alu_mul_seq_if.sv | 30 +++
 rtl/alu_mul_seq.sv | 104 ++++++++++
 2 files changed

// File: rtl/alu_mul_seq_if.sv
// Bus between the pipeline/ALU and the multiply sequencer: start/operands, pipeline ALU
// operands, ALU port drive and result, plus status. The DUT uses the slave modport.
interface alu_mul_seq_if;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] pl_a;
  logic [31:0] pl_b;
  logic [5:0]  pl_fun;
  logic        pl_sign;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_fun;
  logic        alu_sign;
  logic [31:0] alu_z;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, op_a, op_b, pl_a, pl_b, pl_fun, pl_sign, alu_z,
    input  alu_a, alu_b, alu_fun, alu_sign, busy, stall, done, result
  );

  modport slave (
    input  start, op_a, op_b, pl_a, pl_b, pl_fun, pl_sign, alu_z,
    output alu_a, alu_b, alu_fun, alu_sign, busy, stall, done, result
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier sequencer sharing the pipeline ALU (32x32 -> low 32 bits).
// Define ALU_MUL_EARLY_EXIT_EN to stop once the remaining multiplier is zero.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic          clk,
  input logic          reset,
  alu_mul_seq_if.slave bus
);
  localparam logic [5:0] FunAdd = 6'b000000;
  localparam logic [5:0] FunSll = 6'b100000;

  typedef enum logic [1:0] {StIdle, StAdd, StShl, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplr_q;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic [WIDTH-1:0] mplr_shr;
  logic             last_iter;

  assign mplr_shr = mplr_q >> 1;

`ifdef ALU_MUL_EARLY_EXIT_EN
  assign last_iter = (mplr_shr == '0) || (cnt_q == CNT_W'(WIDTH - 1));
`else
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`endif

  // Pipeline owns the ALU only while idle; the shift amount rides on operand A.
  always_comb begin
    bus.alu_a    = bus.pl_a;
    bus.alu_b    = bus.pl_b;
    bus.alu_fun  = bus.pl_fun;
    bus.alu_sign = bus.pl_sign;
    if (state_q == StShl) begin
      bus.alu_a    = WIDTH'(1);
      bus.alu_b    = mcand_q;
      bus.alu_fun  = FunSll;
      bus.alu_sign = 1'b0;
    end else if (state_q != StIdle) begin
      bus.alu_a    = acc_q;
      bus.alu_b    = mcand_q;
      bus.alu_fun  = FunAdd;
      bus.alu_sign = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            acc_q   <= '0;
            mcand_q <= bus.op_a;
            mplr_q  <= bus.op_b;
            cnt_q   <= '0;
`ifdef ALU_MUL_EARLY_EXIT_EN
            if (bus.op_b == '0) state_q <= StDone;
            else state_q <= bus.op_b[0] ? StAdd : StShl;
`else
            state_q <= bus.op_b[0] ? StAdd : StShl;
`endif
          end
        end
        StAdd: begin
          acc_q   <= bus.alu_z;
          state_q <= StShl;
        end
        StShl: begin
          mcand_q <= bus.alu_z;
          mplr_q  <= mplr_shr;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_iter) state_q <= StDone;
          else state_q <= mplr_q[1] ? StAdd : StShl;
        end
        StDone: begin
          result_q <= acc_q;
          done_q   <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy   = (state_q != StIdle);
  assign bus.stall  = bus.busy | bus.start;
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule
